// File: rtl/dmem_lsu_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes,
// controller states and the alignment rule.
package dmem_lsu_pkg;

    localparam int LSU_DATA_WIDTH  = 32;
    localparam int DMEM_ADDR_WIDTH = 10;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } lsu_state_t;

    // True for misaligned halfwords/words and for the reserved size code.
    function automatic logic is_bad_access(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_lsu_lane_align.sv
// Combinational lane steering: load extraction/extension and sub-word store
// merge into a 32-bit memory word. Kept standalone so a cache path can reuse it.
module lsu_lane_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] rd_word,
    input  logic [15:0] st_data,
    output logic [31:0] ld_data,
    output logic [31:0] merged_word
);

    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        shifted = rd_word >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            SZ_BYTE: ld_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: ld_data = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: ld_data = rd_word;
        endcase
    end

    // Each byte lane is replaced only when the store covers it; a halfword
    // store feeds its low/high byte to the even/odd lane of the pair.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic hit;
            logic [7:0] src;
            assign hit = ((size == SZ_BYTE) && (lane == 2'(gi))) ||
                         ((size == SZ_HALF) && (lane[1] == 1'(gi / 2)));
            assign src = (size == SZ_HALF) ? st_data[8*(gi%2) +: 8] : st_data[7:0];
            assign merged_word[8*gi +: 8] = hit ? src : rd_word[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit driving a word-wide, one-cycle-latency data memory port,
// with read-modify-write for byte and halfword stores.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH  = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DMEM_ADDR_WIDTH,
    parameter int XADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [1:0]             req_size,
    input  logic                   req_unsigned,
    input  logic [XADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]  req_wdata,
    output logic                   resp_valid,
    output logic                   resp_err,
    output logic [DATA_WIDTH-1:0]  resp_rdata,
    output logic [ADDR_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0]  mem_write_data,
    output logic                   mem_write_enable,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    input  logic                   mem_read_data_valid
);

    lsu_state_t              state_q, state_d;
    logic                    we_q, we_d;
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic [1:0]              lane_q, lane_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0]   mem_write_data_q, mem_write_data_d;
    logic                    resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;

    logic [DATA_WIDTH-1:0]   ld_data;
    logic [DATA_WIDTH-1:0]   merged_word;

    // Address bits above the memory size are deliberately ignored (wrap).
    logic unused_addr_hi;
    assign unused_addr_hi = ^{req_addr[XADDR_WIDTH-1:ADDR_WIDTH+2], req_wdata[DATA_WIDTH-1:16]};

    lsu_lane_align u_align (
        .lane        (lane_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rd_word     (mem_read_data),
        .st_data     (wdata_q),
        .ld_data     (ld_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d          = state_q;
        we_d             = we_q;
        size_d           = size_q;
        uns_d            = uns_q;
        lane_d           = lane_q;
        wdata_d          = wdata_q;
        mem_address_d    = mem_address_q;
        mem_write_data_d = mem_write_data_q;
        resp_err_d       = resp_err_q;
        resp_rdata_d     = resp_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d          = req_we;
                    size_d        = req_size;
                    uns_d         = req_unsigned;
                    lane_d        = req_addr[1:0];
                    wdata_d       = req_wdata[15:0];
                    mem_address_d = req_addr[ADDR_WIDTH+1:2];
                    if (is_bad_access(req_size, req_addr[1:0])) begin
                        resp_err_d = 1'b1;
                        state_d    = ST_RESP;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        mem_write_data_d = req_wdata;
                        state_d          = ST_WR;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
            end
            ST_RD_ADDR: state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (mem_read_data_valid) begin
                    if (we_q) begin
                        mem_write_data_d = merged_word;
                        state_d          = ST_WR;
                    end else begin
                        resp_rdata_d = ld_data;
                        state_d      = ST_RESP;
                    end
                end
            end
            ST_WR: state_d = ST_RESP;
            ST_RESP: begin
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            we_q             <= 1'b0;
            size_q           <= SZ_BYTE;
            uns_q            <= 1'b0;
            lane_q           <= 2'b00;
            wdata_q          <= '0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
        end else begin
            state_q          <= state_d;
            we_q             <= we_d;
            size_q           <= size_d;
            uns_q            <= uns_d;
            lane_q           <= lane_d;
            wdata_q          <= wdata_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = (state_q == ST_RESP) && !rst;
    assign mem_write_enable = (state_q == ST_WR) && !rst;
    assign resp_err         = resp_err_q;
    assign resp_rdata       = resp_rdata_q;
    assign mem_address      = mem_address_q;
    assign mem_write_data   = mem_write_data_q;

endmodule
